// File: rtl/commit_trace_unit_pkg.sv
// commit_trace_unit_pkg: shared constants and trace entry layout for the commit trace unit
package commit_trace_unit_pkg;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam int ENTRY_W = 96;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] next_pc;
    } trace_entry_t;
endpackage

// File: rtl/commit_trace_unit_trace_fifo.sv
// commit_trace_unit_trace_fifo: single-clock trace FIFO with push/pop, full/empty and a registered-array head
module commit_trace_unit_trace_fifo
    import commit_trace_unit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  trace_entry_t din,
    input  logic         pop,
    output trace_entry_t head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    trace_entry_t mem [DEPTH];
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push = push && (!full || do_pop);
    assign head = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/commit_trace_unit.sv
// commit_trace_unit: buffers retired instructions and tracks counters, flow continuity, halt and hang
module commit_trace_unit
    import commit_trace_unit_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter int          TIMEOUT = 1024,
    parameter logic [31:0] EBREAK  = EBREAK_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_pre_pc,
    input  logic [31:0] instr,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic [31:0] trace_next_pc,
    output logic        trace_drop,
    output logic [63:0] cycle_cnt,
    output logic [63:0] commit_cnt,
    output logic        flow_err,
    output logic [31:0] err_pc,
    output logic        halted,
    output logic        hang
);
    localparam int IW = $clog2(TIMEOUT);
    trace_entry_t head;
    logic full, empty, accept, pop;
    logic have_prev;
    logic [31:0] prev_next;
    logic [IW-1:0] idle;
    assign accept = commit && !halted;
    assign trace_valid = !empty;
    assign pop = trace_valid && trace_ready;
    assign trace_pc = head.pc;
    assign trace_instr = head.instr;
    assign trace_next_pc = head.next_pc;
    commit_trace_unit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ('{pc: commit_pc, instr: instr, next_pc: commit_pre_pc}),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_drop <= 1'b0;
            cycle_cnt <= '0;
            commit_cnt <= '0;
            flow_err <= 1'b0;
            err_pc <= '0;
            halted <= 1'b0;
            hang <= 1'b0;
            have_prev <= 1'b0;
            prev_next <= '0;
            idle <= '0;
        end else begin
            if (!halted) cycle_cnt <= cycle_cnt + 64'd1;
            if (accept && full && !pop) trace_drop <= 1'b1;
            if (accept) begin
                commit_cnt <= commit_cnt + 64'd1;
                prev_next <= commit_pre_pc;
                have_prev <= 1'b1;
                idle <= '0;
                if (have_prev && commit_pc != prev_next) begin
                    flow_err <= 1'b1;
                    if (!flow_err) err_pc <= commit_pc;
                end
                if (instr == EBREAK) halted <= 1'b1;
            end else if (!halted) begin
                // idle saturates at TIMEOUT-1 once hang is raised
                if (idle == IW'(TIMEOUT - 1)) hang <= 1'b1;
                else idle <= idle + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: randomized and directed checks of commit_trace_unit against a queue-based model
module tb_commit_trace_unit;
    localparam int DEPTH = 4;
    localparam int TIMEOUT = 40;
    localparam logic [31:0] EB = 32'h0010_0073;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 0, rst = 1, commit = 0, trace_ready = 0;
    logic [31:0] commit_pc = 0, commit_pre_pc = 0, instr = 0;
    logic trace_valid, trace_drop, flow_err, halted, hang;
    logic [31:0] trace_pc, trace_instr, trace_next_pc, err_pc;
    logic [63:0] cycle_cnt, commit_cnt;
    int errors = 0, checks = 0;
    logic [95:0] q[$];
    logic [63:0] m_cycle, m_commits;
    logic m_drop, m_flow, m_halt, m_hang, m_have;
    logic [31:0] m_errpc, m_prev;
    int m_since;

    always #5 clk = ~clk;

    commit_trace_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .EBREAK(EB)) dut (
        .clk(clk), .rst(rst), .commit(commit), .commit_pc(commit_pc),
        .commit_pre_pc(commit_pre_pc), .instr(instr), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_instr(trace_instr),
        .trace_next_pc(trace_next_pc), .trace_drop(trace_drop), .cycle_cnt(cycle_cnt),
        .commit_cnt(commit_cnt), .flow_err(flow_err), .err_pc(err_pc),
        .halted(halted), .hang(hang)
    );

    task automatic model_clear();
        q.delete();
        m_cycle = 0; m_commits = 0; m_drop = 0; m_flow = 0; m_halt = 0;
        m_hang = 0; m_have = 0; m_errpc = 0; m_prev = 0; m_since = 0;
    endtask

    // one clock: drive at negedge, update the model at the edge, return 1 time unit later
    task automatic step(input logic c, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] npc, input logic rdy);
        logic acc;
        @(negedge clk);
        commit = c; commit_pc = pc; instr = ins; commit_pre_pc = npc; trace_ready = rdy;
        @(posedge clk);
        acc = c && !m_halt;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (!m_halt) m_cycle++;
        if (acc) begin
            if (q.size() < DEPTH) q.push_back({pc, ins, npc});
            else m_drop = 1;
            if (m_have && pc != m_prev) begin
                if (!m_flow) m_errpc = pc;
                m_flow = 1;
            end
            m_have = 1; m_prev = npc; m_commits++; m_since = 0;
            if (ins == EB) m_halt = 1;
        end else if (!m_halt) begin
            m_since++;
            if (m_since >= TIMEOUT) m_hang = 1;
        end
        #1;
    endtask

    // reset with a commit in the same cycle to show reset wins
    task automatic do_reset(input logic c);
        @(negedge clk);
        rst = 1; commit = c; commit_pc = 32'h777; instr = EB; commit_pre_pc = 0; trace_ready = 1;
        @(posedge clk);
        model_clear();
        #1;
        rst = 0; commit = 0;
    endtask

    task automatic test_reset();
        do_reset(1);
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
        checks++; if (cycle_cnt !== 64'd0 || commit_cnt !== 64'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, commit_cnt); end
        checks++; if ({trace_drop, flow_err, halted, hang} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {trace_drop, flow_err, halted, hang}); end
        checks++; if (err_pc !== 32'd0 || trace_pc !== 32'd0) begin errors++; $display("FAIL reset_data: got err_pc=%h trace_pc=%h want 0", err_pc, trace_pc); end
    endtask

    task automatic test_in_order();
        logic [31:0] want [3] = '{32'h0, 32'h4, 32'h8};
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'(4 * i), NOP, 32'(4 * i + 4), 1);
            checks++; if (trace_valid !== 1'b1 || trace_pc !== want[i]) begin errors++; $display("FAIL order_head%0d: got v=%b pc=%h want v=1 pc=%h", i, trace_valid, trace_pc, want[i]); end
        end
        step(0, 0, 0, 0, 1);
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL order_empty: got %b want 0", trace_valid); end
        checks++; if (commit_cnt !== 64'd3 || flow_err !== 1'b0) begin errors++; $display("FAIL order_cnt: got cnt=%0d flow=%b want 3/0", commit_cnt, flow_err); end
    endtask

    task automatic test_flow();
        do_reset(0);
        step(1, 32'h10, NOP, 32'h14, 1);
        step(1, 32'h20, NOP, 32'h24, 1);
        checks++; if (flow_err !== 1'b1 || err_pc !== 32'h20) begin errors++; $display("FAIL flow_first: got flow=%b err_pc=%h want 1/00000020", flow_err, err_pc); end
        step(1, 32'h40, NOP, 32'h44, 1);
        checks++; if (flow_err !== 1'b1 || err_pc !== 32'h20) begin errors++; $display("FAIL flow_keep: got flow=%b err_pc=%h want 1/00000020", flow_err, err_pc); end
    endtask

    task automatic test_full_drop();
        do_reset(0);
        for (int i = 0; i < DEPTH; i++) step(1, 32'(32'h100 + 4 * i), NOP, 32'(32'h104 + 4 * i), 0);
        checks++; if (trace_drop !== 1'b0) begin errors++; $display("FAIL drop_early: got %b want 0", trace_drop); end
        step(1, 32'(32'h100 + 4 * DEPTH), NOP, 32'(32'h104 + 4 * DEPTH), 0);
        checks++; if (trace_drop !== 1'b1 || commit_cnt !== 64'(DEPTH + 1)) begin errors++; $display("FAIL drop_set: got drop=%b cnt=%0d want 1/%0d", trace_drop, commit_cnt, DEPTH + 1); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'(32'h100 + 4 * i)) begin errors++; $display("FAIL drop_drain%0d: got v=%b pc=%h want v=1 pc=%h", i, trace_valid, trace_pc, 32'(32'h100 + 4 * i)); end
            step(0, 0, 0, 0, 1);
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL drop_empty: got %b want 0", trace_valid); end
    endtask

    task automatic test_full_simul();
        int n = 0;
        do_reset(0);
        for (int i = 0; i < DEPTH; i++) step(1, 32'(32'h200 + 4 * i), NOP, 32'(32'h204 + 4 * i), 0);
        step(1, 32'(32'h200 + 4 * DEPTH), NOP, 32'(32'h204 + 4 * DEPTH), 1);
        checks++; if (trace_drop !== 1'b0 || trace_pc !== 32'h204) begin errors++; $display("FAIL simul_nodrop: got drop=%b pc=%h want 0/00000204", trace_drop, trace_pc); end
        for (int i = 0; i < 2 * DEPTH; i++) if (trace_valid) begin n++; step(0, 0, 0, 0, 1); end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL simul_occupancy: got %0d want %0d", n, DEPTH); end
    endtask

    task automatic test_halt();
        int n = 0;
        logic [31:0] last = 0;
        do_reset(0);
        step(1, 32'h0, NOP, 32'h4, 0);
        step(1, 32'h4, NOP, 32'h8, 0);
        step(1, 32'h8, EB, 32'hC, 0);
        checks++; if (halted !== 1'b1 || commit_cnt !== 64'd3 || cycle_cnt !== 64'd3) begin errors++; $display("FAIL halt_set: got h=%b cnt=%0d cyc=%0d want 1/3/3", halted, commit_cnt, cycle_cnt); end
        step(1, 32'h100, NOP, 32'h104, 0);
        for (int i = 0; i < TIMEOUT + 10; i++) step(0, 0, 0, 0, 0);
        checks++; if (commit_cnt !== 64'd3 || cycle_cnt !== 64'd3 || hang !== 1'b0 || flow_err !== 1'b0) begin errors++; $display("FAIL halt_frozen: got cnt=%0d cyc=%0d hang=%b flow=%b want 3/3/0/0", commit_cnt, cycle_cnt, hang, flow_err); end
        for (int i = 0; i < 2 * DEPTH; i++) if (trace_valid) begin n++; last = trace_instr; step(0, 0, 0, 0, 1); end
        checks++; if (n != 3 || last !== EB) begin errors++; $display("FAIL halt_entries: got n=%0d last=%h want 3/%h", n, last, EB); end
    endtask

    task automatic test_hang();
        do_reset(0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, 0);
        checks++; if (hang !== 1'b0 || cycle_cnt !== 64'(TIMEOUT - 1)) begin errors++; $display("FAIL hang_early: got hang=%b cyc=%0d want 0/%0d", hang, cycle_cnt, TIMEOUT - 1); end
        step(0, 0, 0, 0, 0);
        checks++; if (hang !== 1'b1 || cycle_cnt !== 64'(TIMEOUT)) begin errors++; $display("FAIL hang_set: got hang=%b cyc=%0d want 1/%0d", hang, cycle_cnt, TIMEOUT); end
        step(1, 32'h300, NOP, 32'h304, 1);
        checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_sticky: got %b want 1", hang); end
    endtask

    task automatic test_random();
        logic [31:0] pc = 32'h1000, ins, npc;
        logic c;
        logic [95:0] exp_head;
        do_reset(0);
        for (int i = 0; i < 300; i++) begin
            c = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) pc = $urandom & ~32'h3;
            ins = $urandom;
            if (ins == EB) ins = NOP;
            npc = ($urandom_range(0, 7) == 0) ? ($urandom & ~32'h3) : pc + 4;
            step(c, pc, ins, npc, $urandom_range(0, 2) != 0);
            if (c) pc = npc;
            exp_head = (q.size() != 0) ? q[0] : '0;
            checks++; if (trace_valid !== (q.size() != 0) || {trace_pc, trace_instr, trace_next_pc} !== exp_head) begin errors++; $display("FAIL rand_head@%0d: got v=%b %h want v=%b %h", i, trace_valid, {trace_pc, trace_instr, trace_next_pc}, q.size() != 0, exp_head); end
            checks++; if (cycle_cnt !== m_cycle || commit_cnt !== m_commits) begin errors++; $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d", i, cycle_cnt, commit_cnt, m_cycle, m_commits); end
            checks++; if ({trace_drop, flow_err, halted, hang} !== {m_drop, m_flow, m_halt, m_hang} || err_pc !== m_errpc) begin errors++; $display("FAIL rand_flags@%0d: got %b err_pc=%h want %b err_pc=%h", i, {trace_drop, flow_err, halted, hang}, err_pc, {m_drop, m_flow, m_halt, m_hang}, m_errpc); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        step(1, 32'h400, NOP, 32'h404, 0);
        step(1, 32'h480, NOP, 32'h484, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 32'h484, NOP, 32'h484, 0);
        do_reset(1);
        checks++; if (trace_valid !== 1'b0 || cycle_cnt !== 64'd0 || commit_cnt !== 64'd0) begin errors++; $display("FAIL mid_reset: got v=%b cyc=%0d cnt=%0d want 0/0/0", trace_valid, cycle_cnt, commit_cnt); end
        checks++; if ({trace_drop, flow_err, halted, hang} !== 4'b0 || err_pc !== 32'd0) begin errors++; $display("FAIL mid_reset_flags: got %b err_pc=%h want 0000/0", {trace_drop, flow_err, halted, hang}, err_pc); end
        step(1, 32'h500, NOP, 32'h504, 0);
        checks++; if (flow_err !== 1'b0 || trace_pc !== 32'h500) begin errors++; $display("FAIL mid_first_commit: got flow=%b pc=%h want 0/00000500", flow_err, trace_pc); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_in_order();
        test_flow();
        test_full_drop();
        test_full_simul();
        test_halt();
        test_hang();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_unit.md
Name: commit_trace_unit

Overview:
- Sits directly downstream of the CPU top. Consumes its retirement interface: commit, commit_pc, instr, commit_pre_pc (the architectural next PC of the retiring instruction).
- Buffers each retired instruction in a trace FIFO that the bench/debug host drains through a valid/ready port.
- Keeps cycle and retire counters, checks control-flow continuity between consecutive commits, and raises halt (ebreak) and hang (no-commit watchdog) flags.

Parameters:
DEPTH, 16, trace FIFO entries; power of two, at least 2
TIMEOUT, 1024, cycles without a commit before hang is raised; at least 2
EBREAK, 32'h0010_0073, instruction encoding that marks program end

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
commit  input  1  one instruction retires this cycle
commit_pc  input  32  PC of the retiring instruction
commit_pre_pc  input  32  architectural next PC of the retiring instruction
instr  input  32  encoding of the retiring instruction
trace_valid  output  1  FIFO head entry available
trace_ready  input  1  consumer accepts head entry
trace_pc  output  32  head entry PC
trace_instr  output  32  head entry instruction
trace_next_pc  output  32  head entry next PC
trace_drop  output  1  sticky: a commit was lost because the FIFO was full
cycle_cnt  output  64  cycles since reset; freezes once halted
commit_cnt  output  64  retired instructions; freezes once halted
flow_err  output  1  sticky: commit_pc did not match the previous commit_pre_pc
err_pc  output  32  commit_pc of the first flow violation
halted  output  1  sticky: EBREAK retired
hang  output  1  sticky: watchdog expired

Behaviour:
Reset:
- The FIFO empties, so trace_valid=0.
- All counters, all sticky flags and err_pc go to 0.
- have_prev goes to 0.
- trace_* data outputs are don't-care while trace_valid=0; drive them to 0.

Accepted commit:
- A commit is accepted only when commit=1 and halted=0.
- A commit arriving after halted=1 is ignored entirely: no push, no count, no check.

FIFO:
- Push: an accepted commit writes {commit_pc, instr, commit_pre_pc} into the FIFO. It is visible at the head one cycle later at the earliest, so write-to-trace_valid latency is 1.
- Pop: occurs when trace_valid && trace_ready. Head data is held stable while trace_valid=1 && trace_ready=0.
- Full with push and no pop: the entry is dropped, trace_drop is set, and commit_cnt still increments.
- Full with push and pop in the same cycle: both happen and nothing is dropped. The occupancy counter is ceil(log2(DEPTH))+1 bits wide.
- Empty with push: pop is not possible that cycle; no bypass from input to output.
- Read and write pointers wrap modulo DEPTH.

Counters:
- cycle_cnt increments every cycle after reset while halted=0.
- The cycle in which EBREAK is accepted still increments both cycle_cnt and commit_cnt; from the next cycle both are frozen.
- Both counters wrap modulo 2^64.

Flow check:
- Registers prev_next = commit_pre_pc and have_prev=1 on each accepted commit.
- On an accepted commit with have_prev=1 and commit_pc != prev_next: flow_err is set.
- err_pc is latched only when flow_err was 0, so it records the first violation only.
- The first commit after reset is never checked.

Halt:
- Accepting a commit with instr == EBREAK sets halted in the next cycle.
- That EBREAK entry is still pushed into the FIFO.

Watchdog:
- An idle counter resets to 0 on every accepted commit and otherwise increments while halted=0.
- hang is set when the counter reaches TIMEOUT-1 with no commit in that cycle. The counter then saturates.
- halted=1 stops the watchdog, so hang never rises after a halt.

Simultaneous events:
- In one cycle, flow check, push, count and halt detection all act on the same accepted commit.

Reset mid-operation:
- Reset overrides every other event in the same cycle. FIFO contents are discarded.

Decomposition:
- Shared define file holds the EBREAK encoding constant and the trace entry width (96).
- One natural sub-module: trace_fifo. It is a synchronous single-clock FIFO with parameter DEPTH, push/pop ports, full/empty flags and a registered head.
- The parent holds counters, the flow checker, halt detection and the watchdog.

Test Plan:
- Reset, then 3 commits at pc 0x0, 0x4, 0x8 with next_pc 0x4, 0x8, 0xC, trace_ready=1 -> 3 entries pop in order, commit_cnt=3, flow_err=0.
- Commits at 0x10 (next 0x14), then 0x20 -> flow_err=1, err_pc=0x20. A later mismatch at 0x40 leaves err_pc=0x20.
- trace_ready=0 with DEPTH+1 commits -> trace_drop=1, FIFO holds the first DEPTH entries in order, commit_cnt=DEPTH+1.
- Full FIFO, one commit with trace_ready=1 in the same cycle -> no drop, occupancy stays DEPTH.
- Commit instr=32'h0010_0073 -> halted=1 next cycle; a further commit (pc 0x100) is ignored; counters frozen; entry count includes EBREAK.
- No commits for TIMEOUT cycles after reset -> hang=1 exactly at cycle TIMEOUT. A rst pulse mid-FIFO clears trace_valid, counters and all flags next cycle.
